// File: rtl/symbol_strobe_recovery.sv
// Symbol strobe recovery: regenerates a one-cycle mid-symbol sample strobe
// from an asynchronous NRZ bit stream, aligned to the incoming transitions,
// and reports the sampled bit plus a timing-lock flag.
module symbol_strobe_recovery #(
  parameter int I_CLK_FRQ  = 100_000_000,
  parameter int FREQUENCY  = 1_000,
  parameter int TOL_DIV    = 8,
  parameter int LOCK_EDGES = 4,
  parameter int MAX_RUN    = 16
) (
  input  logic i_clk,
  input  logic rst,
  input  logic en,
  input  logic i_bit,
  output logic o_strobe,
  output logic o_bit,
  output logic o_locked
);

  // Clock cycles per symbol; the design assumes DIV >= 4.
  localparam int DIV = I_CLK_FRQ / FREQUENCY;
  // Edge tolerance, in cycles, either side of the nominal edge position.
  localparam int TOL = DIV / TOL_DIV;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW  = $clog2(LOCK_EDGES + 1);
  localparam int RW  = $clog2(MAX_RUN + 1);

  localparam logic [CW-1:0] CTR_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CTR_MID  = CW'(DIV / 2 - 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_EDGES);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_RUN);
  // Late side of the window starts here; early side ends at TOL-1.
  localparam logic [31:0]   WIN_LATE  = 32'(DIV - 1 - TOL);
  localparam logic [31:0]   WIN_EARLY = (TOL > 0) ? 32'(TOL - 1) : 32'd0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ctr_q, ctr_d;
  logic [GW-1:0]   good_q, good_d;
  logic [RW-1:0]   run_q, run_d;
  logic            locked_d, bit_d, strobe_d;

  logic            s1, s2, s3;
  logic            edge_det;
  logic [31:0]     phase;
  logic            in_window;

  // Input synchronizer plus delay flop; runs whether or not en is high so a
  // transition seen while disabled is simply lost.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_bit;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 ^ s3;

  // Phase of an edge is the counter value in the edge cycle; DIV-1 is nominal.
  assign phase     = 32'(ctr_q);
  assign in_window = (phase >= WIN_LATE) || ((TOL > 0) && (phase <= WIN_EARLY));

  // Next-state, counter and output computation; everything holds unless en.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    good_d   = good_q;
    run_d    = run_q;
    locked_d = o_locked;
    bit_d    = o_bit;
    strobe_d = 1'b0;

    if (en) begin
      ctr_d = (ctr_q == CTR_LAST) ? '0 : ctr_q + CW'(1);
      case (state_q)
        IDLE: begin
          // First edge only establishes phase; it is not scored.
          if (edge_det) begin
            state_d = TRACK;
            ctr_d   = '0;
            good_d  = '0;
            run_d   = '0;
          end
        end
        TRACK: begin
          if (edge_det) begin
            ctr_d = '0;
            run_d = '0;
            if (in_window) begin
              if (good_q < GOOD_MAX) begin
                good_d = good_q + GW'(1);
              end
              if (good_d == GOOD_MAX) begin
                locked_d = 1'b1;
              end
            end else begin
              good_d   = '0;
              locked_d = 1'b0;
            end
          end else if (ctr_q == CTR_MID) begin
            // Mid-symbol: emit the strobe and sample; an edge here would
            // have taken the branch above and suppressed it.
            strobe_d = 1'b1;
            bit_d    = s2;
            run_d    = run_q + RW'(1);
            if (run_d == RUN_MAX) begin
              state_d  = IDLE;
              locked_d = 1'b0;
              good_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      good_q   <= '0;
      run_q    <= '0;
      o_strobe <= 1'b0;
      o_bit    <= 1'b0;
      o_locked <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      good_q   <= good_d;
      run_q    <= run_d;
      o_strobe <= strobe_d;
      o_bit    <= bit_d;
      o_locked <= locked_d;
    end
  end

endmodule

// File: tb/tb_symbol_strobe_recovery.sv
// Directed bench for symbol_strobe_recovery with DIV=10, TOL=1,
// LOCK_EDGES=4, MAX_RUN=16. An i_bit change applied just after a clock edge
// is detected two cycles later; the strobe follows 8 cycles after the change.
module tb_symbol_strobe_recovery;

  logic i_clk = 1'b0;
  logic rst   = 1'b1;
  logic en    = 1'b1;
  logic i_bit = 1'b0;
  logic o_strobe, o_bit, o_locked;

  int checks   = 0;
  int failures = 0;

  symbol_strobe_recovery #(
    .I_CLK_FRQ (1000),
    .FREQUENCY (100),
    .TOL_DIV   (8),
    .LOCK_EDGES(4),
    .MAX_RUN   (16)
  ) dut (
    .i_clk   (i_clk),
    .rst     (rst),
    .en      (en),
    .i_bit   (i_bit),
    .o_strobe(o_strobe),
    .o_bit   (o_bit),
    .o_locked(o_locked)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0b expected=%0b", tag, idx, obs, exp);
    end
  endtask

  // Drive one symbol of value v for len cycles. Strobes are expected 8, 18,
  // 28... cycles after the change, at most max_strb of them. lock3 is the
  // lock flag expected once this symbol's edge has been scored, lock_end the
  // flag expected on the final cycle.
  task automatic run_symbol(input logic v, input int len, input int max_strb,
                            input logic lock3, input logic lock_end);
    logic exp_s;
    i_bit = v;
    for (int i = 1; i <= len; i++) begin
      step();
      exp_s = ((i >= 8) && ((i - 8) % 10 == 0) && ((i - 8) / 10 < max_strb)) ? 1'b1 : 1'b0;
      chk("strobe", i, o_strobe, exp_s);
      if (exp_s) chk("bit", i, o_bit, v);
      if (i == 3) chk("lock3", i, o_locked, lock3);
      if (i == len) chk("lock_end", i, o_locked, lock_end);
    end
  endtask

  initial begin
    // 1: reset with i_bit toggling
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_bit = ~i_bit;
      step();
      chk("rst_strobe", i, o_strobe, 1'b0);
      chk("rst_bit", i, o_bit, 1'b0);
      chk("rst_locked", i, o_locked, 1'b0);
    end
    rst   = 1'b0;
    i_bit = 1'b0;
    step();
    chk("post_rst_strobe", 0, o_strobe, 1'b0);
    chk("post_rst_locked", 0, o_locked, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("idle_strobe", i, o_strobe, 1'b0);
    end

    // 2: nominal alternation, lock after the 5th edge
    run_symbol(1'b1, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b1, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b1, 10, 99, 1'b1, 1'b1);

    // 3: spacings 9 (p=8), 11 (p=0) keep lock; 13 (p=2) drops it; relock
    run_symbol(1'b0, 9,  99, 1'b1, 1'b1);
    run_symbol(1'b1, 11, 99, 1'b1, 1'b1);
    run_symbol(1'b0, 13, 99, 1'b1, 1'b1);
    run_symbol(1'b1, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b1, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b1, 10, 99, 1'b1, 1'b1);

    // 4: hold i_bit; one strobe already followed the last edge, so 15 more
    //    complete the run of 16 before tracking is abandoned
    chk("pre_hold_locked", 0, o_locked, 1'b1);
    run_symbol(1'b1, 200, 15, 1'b1, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b1, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b1, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b1, 1'b1);

    // 5: en low for 7 cycles mid-symbol delays the strobe by 7
    i_bit = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("en_strobe", i, o_strobe, (i == 15) ? 1'b1 : 1'b0);
      if (i == 15) chk("en_bit", i, o_bit, 1'b1);
      if (i == 3 || i == 10 || i == 20) chk("en_locked", i, o_locked, 1'b1);
      if (i == 5) en = 1'b0;
      if (i == 12) en = 1'b1;
    end
    //    reset pulse while tracking
    rst   = 1'b1;
    i_bit = 1'b0;
    step();
    chk("mid_rst_strobe", 0, o_strobe, 1'b0);
    chk("mid_rst_bit", 0, o_bit, 1'b0);
    chk("mid_rst_locked", 0, o_locked, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("after_rst_strobe", i, o_strobe, 1'b0);
    end

    // 6: edge at p=4 suppresses the strobe and clears the lock
    run_symbol(1'b1, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b1, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b1, 10, 99, 1'b1, 1'b1);
    run_symbol(1'b0, 5,  99, 1'b1, 1'b1);
    run_symbol(1'b1, 10, 99, 1'b0, 1'b0);
    run_symbol(1'b0, 10, 99, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
